// File: rtl/rv32i_multicycle_controller.sv
// rtl/rv32i_multicycle_controller.sv - multicycle RV32I control FSM with memory handshake watchdog and sticky traps
package rv32i_ctrl_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_control_t;
endpackage

module rv32i_multicycle_controller
    import rv32i_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ena,
    input  logic [6:0]   i_op,
    input  logic [2:0]   i_funct3,
    input  logic         i_funct7_5,
    input  logic         i_alu_zero,
    input  logic         i_mem_ready,
    output logic         o_mem_req,
    output logic         o_mem_write,
    output logic         o_ir_write,
    output logic         o_pc_write,
    output logic         o_reg_write,
    output logic         o_adr_src,
    output logic [1:0]   o_alu_src_a,
    output logic [1:0]   o_alu_src_b,
    output logic [1:0]   o_res_src,
    output logic [2:0]   o_imm_src,
    output alu_control_t o_alu_control,
    output logic         o_illegal_instr,
    output logic         o_mem_timeout,
    output logic [3:0]   o_state_dbg
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADR = 4'd2, S_MEM_READ = 4'd3,
        S_MEM_WRITE = 4'd4, S_MEM_WB = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
        S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR_TGT = 4'd11,
        S_JALR_JUMP = 4'd12, S_LUI = 4'd13, S_TRAP = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam int WDW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [WDW-1:0]   r_wdog;
    logic             r_illegal;
    logic             r_timeout;
    logic             w_ready;
    logic             w_mem_state;
    logic             w_set_illegal;
    logic             w_set_timeout;
    logic             w_taken;

    assign w_ready     = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    // Branch ALU op leaves zero set when the comparison is false (SLT/SLTU) or operands equal (SUB).
    assign w_taken     = (i_funct3[0] ^ i_funct3[2]) ? !i_alu_zero : i_alu_zero;

    function automatic alu_control_t alu_decode(input logic [2:0] f3, input logic is_r, input logic f7);
        case (f3)
            3'b000:  alu_decode = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_FETCH;
            r_wdog    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else if (i_ena) begin
            r_state <= w_next;
            r_wdog  <= (w_mem_state && !w_ready && w_next == r_state) ? r_wdog + WDW'(1) : '0;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_FETCH:     if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR_TGT;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_ALU_WB;
                    OP_BRANCH: begin
                        if (i_funct3[2:1] == 2'b01) begin
                            w_next        = S_TRAP;
                            w_set_illegal = 1'b1;
                        end else begin
                            w_next = S_BRANCH;
                        end
                    end
                    default: begin
                        w_next        = S_TRAP;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR:   w_next = (i_op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (w_ready) w_next = S_MEM_WB;
            S_MEM_WRITE: if (w_ready) w_next = S_FETCH;
            S_MEM_WB, S_ALU_WB, S_BRANCH: w_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_JALR_JUMP: w_next = S_ALU_WB;
            S_JALR_TGT:  w_next = S_JALR_JUMP;
            default:     w_next = S_TRAP;
        endcase
        if (MEM_TIMEOUT != 0 && w_mem_state && !w_ready && r_wdog == WDW'(MEM_TIMEOUT - 1)) begin
            w_next        = S_TRAP;
            w_set_timeout = 1'b1;
        end
    end

    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_adr_src     = 1'b0;
        o_alu_src_a   = 2'd0;
        o_alu_src_b   = 2'd0;
        o_res_src     = 2'd0;
        o_alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = 2'd2;
                o_res_src   = 2'd1;
                o_ir_write  = w_ready;
                o_pc_write  = w_ready;
            end
            S_DECODE:    begin o_alu_src_a = 2'd1; o_alu_src_b = 2'd1; end
            S_MEM_ADR:   begin o_alu_src_a = 2'd2; o_alu_src_b = 2'd1; end
            S_MEM_READ:  begin o_mem_req = 1'b1; o_adr_src = 1'b1; o_res_src = 2'd2; end
            S_MEM_WRITE: begin
                o_mem_req   = 1'b1;
                o_adr_src   = 1'b1;
                o_res_src   = 2'd2;
                o_mem_write = w_ready;
            end
            S_MEM_WB:    o_reg_write = 1'b1;
            S_EXEC_R: begin
                o_alu_src_a   = 2'd2;
                o_alu_control = alu_decode(i_funct3, 1'b1, i_funct7_5);
            end
            S_EXEC_I: begin
                o_alu_src_a   = 2'd2;
                o_alu_src_b   = 2'd1;
                o_alu_control = alu_decode(i_funct3, 1'b0, i_funct7_5);
            end
            S_ALU_WB:    begin o_res_src = 2'd2; o_reg_write = 1'b1; end
            S_BRANCH: begin
                o_alu_src_a   = 2'd2;
                o_res_src     = 2'd2;
                o_pc_write    = w_taken;
                o_alu_control = !i_funct3[2] ? ALU_SUB : (i_funct3[1] ? ALU_SLTU : ALU_SLT);
            end
            S_JAL, S_JALR_JUMP: begin
                o_alu_src_a = 2'd1;
                o_alu_src_b = 2'd2;
                o_res_src   = 2'd2;
                o_pc_write  = 1'b1;
            end
            S_JALR_TGT:  begin o_alu_src_a = 2'd2; o_alu_src_b = 2'd1; end
            S_LUI:       begin o_alu_src_a = 2'd3; o_alu_src_b = 2'd1; end
            default: ;
        endcase
        if (!i_rst || !i_ena) begin
            o_mem_req   = 1'b0;
            o_mem_write = 1'b0;
            o_ir_write  = 1'b0;
            o_pc_write  = 1'b0;
            o_reg_write = 1'b0;
        end
    end

    always_comb begin
        case (i_op)
            OP_STORE:          o_imm_src = 3'd3;
            OP_BRANCH:         o_imm_src = 3'd1;
            OP_JAL:            o_imm_src = 3'd2;
            OP_LUI, OP_AUIPC:  o_imm_src = 3'd4;
            default:           o_imm_src = 3'd0;
        endcase
    end

    assign o_illegal_instr = r_illegal;
    assign o_mem_timeout   = r_timeout;
    assign o_state_dbg     = r_state;
endmodule
